// File: rtl/ct_wrr_merge.sv
// ct_wrr_merge: weighted round-robin merge of RADIX valid/ready packet streams into one.
// Define CT_WRR_MERGE_OREG_EN to put a 2-entry skid buffer on the merged output.
module ct_wrr_merge #(
   parameter int  RADIX   = 4,
   parameter int  WIDTH   = 32,
   parameter int  EOP_LOC = 0,
   parameter int  WBITS   = 4,
   localparam int RADBITS = (RADIX > 2) ? $clog2(RADIX) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [RADIX*WIDTH-1:0] i_data,
   input  logic [RADIX-1:0]       i_valid,
   output logic [RADIX-1:0]       o_ready,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   input  logic                   cfg_wr,
   input  logic [RADBITS-1:0]     cfg_idx,
   input  logic [WBITS-1:0]       cfg_weight,
   output logic [RADBITS-1:0]     o_cur,
   output logic                   o_granted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SOP  = 2'd1,
      S_MID  = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [RADBITS-1:0] r_cur, r_last, w_cur_nxt, w_last_nxt;
   logic [WBITS-1:0]   r_sent, w_sent_nxt, w_sent_inc;
   logic [WBITS-1:0]   r_weight [RADIX];

   logic [WIDTH-1:0]   w_sel_data;
   logic               w_sel_valid, w_fwd_en, w_push_rdy, w_beat, w_eop;
   logic               w_found;
   logic [RADBITS-1:0] w_found_idx;

   assign w_sel_data  = i_data[WIDTH*int'(r_cur) +: WIDTH];
   assign w_sel_valid = i_valid[r_cur];
   assign w_fwd_en    = (r_state != S_IDLE);
   assign w_sent_inc  = r_sent + WBITS'(1);

   // Rotating search starting just after the last input that held the grant.
   always_comb begin
      logic [RADBITS:0]   w_pos;
      logic [RADBITS-1:0] w_idx;
      w_found     = 1'b0;
      w_found_idx = '0;
      w_pos       = '0;
      w_idx       = '0;
      for (int k = 1; k <= RADIX; k++) begin
         w_pos = {1'b0, r_last} + (RADBITS+1)'(k);
         if (w_pos >= (RADBITS+1)'(RADIX)) w_pos = w_pos - (RADBITS+1)'(RADIX);
         w_idx = w_pos[RADBITS-1:0];
         if (!w_found && i_valid[w_idx] && (r_weight[w_idx] != '0)) begin
            w_found     = 1'b1;
            w_found_idx = w_idx;
         end
      end
   end

`ifdef CT_WRR_MERGE_OREG_EN
   logic [WIDTH-1:0] r_buf [2];
   logic             r_wr_ptr, r_rd_ptr;
   logic [1:0]       r_cnt;
   logic             w_pop;

   assign w_push_rdy = (r_cnt != 2'd2);
   assign w_beat     = w_fwd_en && w_sel_valid && w_push_rdy;
   assign o_valid    = (r_cnt != 2'd0);
   assign o_data     = r_buf[r_rd_ptr];
   assign w_pop      = o_valid && i_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt    <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_beat) begin
            r_buf[r_wr_ptr] <= w_sel_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= r_cnt + {1'b0, w_beat} - {1'b0, w_pop};
      end
   end
`else
   assign w_push_rdy = i_ready;
   assign w_beat     = w_fwd_en && w_sel_valid && i_ready;
   assign o_valid    = w_fwd_en && w_sel_valid;
   assign o_data     = w_sel_data;
`endif

   assign w_eop = w_beat && w_sel_data[EOP_LOC];

   // Only the granted input sees ready; it never depends on any i_valid.
   always_comb begin
      o_ready = '0;
      if (w_fwd_en) o_ready[r_cur] = w_push_rdy;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_last_nxt  = r_last;
      w_sent_nxt  = r_sent;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_SOP;
               w_cur_nxt   = w_found_idx;
               w_sent_nxt  = '0;
            end
         end
         S_SOP, S_MID: begin
            if ((r_state == S_SOP) && !w_sel_valid) begin
               w_state_nxt = S_IDLE;
               w_last_nxt  = r_cur;
            end else if (w_eop) begin
               // Weight is read at EOP so a mid-packet rewrite takes effect here.
               if (w_sent_inc >= r_weight[r_cur]) begin
                  w_state_nxt = S_IDLE;
                  w_last_nxt  = r_cur;
                  w_sent_nxt  = '0;
               end else begin
                  w_state_nxt = S_SOP;
                  w_sent_nxt  = w_sent_inc;
               end
            end else if (w_beat) begin
               w_state_nxt = S_MID;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_last  <= RADBITS'(RADIX-1);
         r_sent  <= '0;
         for (int i = 0; i < RADIX; i++) r_weight[i] <= WBITS'(1);
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_last  <= w_last_nxt;
         r_sent  <= w_sent_nxt;
         if (cfg_wr && (int'(cfg_idx) < RADIX)) r_weight[cfg_idx] <= cfg_weight;
      end
   end

   assign o_cur     = r_cur;
   assign o_granted = (r_state != S_IDLE);

endmodule

// File: tb/tb_ct_wrr_merge.sv
// Bench for ct_wrr_merge (default build): per-cycle vector table for plain RR,
// then packet-level sequences checked against hand-ordered expected beats.
module tb_ct_wrr_merge;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] i_data;
   logic [3:0]   i_valid;
   logic [3:0]   o_ready;
   logic [31:0]  o_data;
   logic         o_valid;
   logic         i_ready;
   logic         cfg_wr;
   logic [1:0]   cfg_idx;
   logic [3:0]   cfg_weight;
   logic [1:0]   o_cur;
   logic         o_granted;

   always #5 clk = ~clk;

   ct_wrr_merge #(.RADIX(4), .WIDTH(32), .EOP_LOC(0), .WBITS(4)) dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .cfg_wr(cfg_wr),
      .cfg_idx(cfg_idx), .cfg_weight(cfg_weight), .o_cur(o_cur), .o_granted(o_granted)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // values applied to the DUT at the next falling edge
   logic       sh_rst = 1'b0;
   logic       sh_rdy = 1'b1;
   logic       sh_cfg_wr = 1'b0;
   logic [1:0] sh_cfg_idx = 2'd0;
   logic [3:0] sh_cfg_w = 4'd0;

   logic [31:0] src_q [4][$];
   logic [31:0] exp_q [$];

   logic       s_valid, s_gr;
   logic [3:0] s_ready;
   logic [1:0] s_cur;

   typedef struct {
      logic [3:0]  vld;
      logic        exp_v;
      logic [3:0]  exp_r;
      logic        exp_g;
      logic [1:0]  exp_c;
      logic [31:0] exp_d;
   } vec_t;
   vec_t vt [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wd(input int s, input int p, input int b, input logic eop);
      return {s[7:0], p[7:0], b[14:0], eop};
   endfunction

   // One clock: drive at negedge, sample 1 time unit later, score beats, wait posedge.
   task automatic cycle();
      logic [3:0]   vld;
      logic [127:0] dat;
      @(negedge clk);
      vld = '0;
      dat = '0;
      for (int i = 0; i < 4; i++) begin
         if (src_q[i].size() > 0) begin
            vld[i] = 1'b1;
            dat[32*i +: 32] = src_q[i][0];
         end
      end
      reset      = sh_rst;
      i_ready    = sh_rdy;
      cfg_wr     = sh_cfg_wr;
      cfg_idx    = sh_cfg_idx;
      cfg_weight = sh_cfg_w;
      i_valid    = vld;
      i_data     = dat;
      #1;
      s_valid = o_valid;
      s_ready = o_ready;
      s_gr    = o_granted;
      s_cur   = o_cur;
      if (o_valid && i_ready) begin
         if (exp_q.size() == 0) chk("unexpected_beat", o_data, 32'hx);
         else chk("beat_data", o_data, exp_q.pop_front());
      end
      for (int i = 0; i < 4; i++)
         if (o_ready[i] && vld[i]) void'(src_q[i].pop_front());
      @(posedge clk);
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [3:0] w);
      sh_cfg_wr  = 1'b1;
      sh_cfg_idx = idx;
      sh_cfg_w   = w;
      cycle();
      sh_cfg_wr  = 1'b0;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) src_q[i].delete();
      exp_q.delete();
      sh_rst    = 1'b0;
      sh_rdy    = 1'b1;
      sh_cfg_wr = 1'b0;
      repeat (2) cycle();
      sh_rst = 1'b1;
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk(nm, exp_q.size(), 0);
   endtask

   initial begin
      int eg [5];
      int ev [5];
      logic tog, added, pre;
      int n;

      reset = 1'b0; i_data = '0; i_valid = '0; i_ready = 1'b1;
      cfg_wr = 1'b0; cfg_idx = '0; cfg_weight = '0;

      // Plain RR with default weights: two 1-beat packets per input, idle cycle between grants.
      vt[0]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
      vt[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hD000_0001};
      vt[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
      vt[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hD000_0011};
      vt[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 32'h0};
      vt[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hD000_0021};
      vt[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0};
      vt[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hD000_0031};
      vt[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h0};
      vt[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hD000_0001};
      vt[10] = '{4'b1110, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
      vt[11] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hD000_0011};
      vt[12] = '{4'b1100, 1'b0, 4'b0000, 1'b0, 2'd1, 32'h0};
      vt[13] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hD000_0021};
      vt[14] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0};
      vt[15] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hD000_0031};
      vt[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h0};
      vt[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h0};

      do_reset();
      for (int v = 0; v < 18; v++) begin
         @(negedge clk);
         reset   = 1'b1;
         cfg_wr  = 1'b0;
         i_ready = 1'b1;
         i_valid = vt[v].vld;
         i_data  = {32'hD000_0031, 32'hD000_0021, 32'hD000_0011, 32'hD000_0001};
         #1;
         chk($sformatf("rr_valid[%0d]", v), o_valid, vt[v].exp_v);
         chk($sformatf("rr_ready[%0d]", v), o_ready, vt[v].exp_r);
         chk($sformatf("rr_granted[%0d]", v), o_granted, vt[v].exp_g);
         chk($sformatf("rr_cur[%0d]", v), o_cur, vt[v].exp_c);
         if (vt[v].exp_v) chk($sformatf("rr_data[%0d]", v), o_data, vt[v].exp_d);
         @(posedge clk);
      end

      // Weights 3,1,1,1 with all inputs saturated: 0,0,0,1,2,3 repeating over 60 packets.
      do_reset();
      cfg_write(2'd0, 4'd3); cfg_write(2'd1, 4'd1); cfg_write(2'd2, 4'd1); cfg_write(2'd3, 4'd1);
      for (int s = 0; s < 4; s++)
         for (int p = 0; p < 40; p++) src_q[s].push_back(wd(s, p, 0, 1'b1));
      for (int r = 0; r < 10; r++) begin
         exp_q.push_back(wd(0, 3*r, 0, 1'b1));
         exp_q.push_back(wd(0, 3*r+1, 0, 1'b1));
         exp_q.push_back(wd(0, 3*r+2, 0, 1'b1));
         exp_q.push_back(wd(1, r, 0, 1'b1));
         exp_q.push_back(wd(2, r, 0, 1'b1));
         exp_q.push_back(wd(3, r, 0, 1'b1));
      end
      drain("wrr_order_timeout", 200);

      // 5-beat packet on input 2 under toggling ready; input 1 arrives mid-packet.
      do_reset();
      for (int b = 0; b < 5; b++) begin
         src_q[2].push_back(wd(2, 0, b, b == 4));
         exp_q.push_back(wd(2, 0, b, b == 4));
      end
      exp_q.push_back(wd(1, 0, 0, 1'b1));
      tog = 1'b1; added = 1'b0; n = 0;
      while (exp_q.size() > 0 && n < 60) begin
         sh_rdy = tog;
         tog = ~tog;
         pre = (src_q[2].size() > 0);
         cycle();
         if (pre) chk("mid_ready1", s_ready[1], 1'b0);
         if (!added && src_q[2].size() == 3) begin
            src_q[1].push_back(wd(1, 0, 0, 1'b1));
            added = 1'b1;
         end
         n++;
      end
      chk("pkt_timeout", exp_q.size(), 0);
      sh_rdy = 1'b1;

      // Weight 0 blocks input 1; rewriting it to 2 allows two packets per grant.
      do_reset();
      cfg_write(2'd1, 4'd0);
      for (int p = 0; p < 3; p++) src_q[1].push_back(wd(1, p, 0, 1'b1));
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("w0_valid", s_valid, 1'b0);
         chk("w0_granted", s_gr, 1'b0);
      end
      for (int p = 0; p < 3; p++) exp_q.push_back(wd(1, p, 0, 1'b1));
      cfg_write(2'd1, 4'd2);
      chk("w_write_cycle_granted", s_gr, 1'b0);
      eg = '{0, 1, 1, 0, 1};
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("w2_granted[%0d]", k), s_gr, eg[k]);
         chk($sformatf("w2_valid[%0d]", k), s_valid, eg[k]);
      end
      chk("w2_drain", exp_q.size(), 0);

      // Weight 4 on input 0 but only one packet: release at SOP, then input 3.
      do_reset();
      cfg_write(2'd0, 4'd4);
      src_q[0].push_back(wd(0, 0, 0, 1'b1));
      exp_q.push_back(wd(0, 0, 0, 1'b1));
      exp_q.push_back(wd(3, 0, 0, 1'b1));
      eg = '{0, 1, 1, 0, 1};
      ev = '{0, 1, 0, 0, 1};
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("sop_rel_granted[%0d]", k), s_gr, eg[k]);
         chk($sformatf("sop_rel_valid[%0d]", k), s_valid, ev[k]);
         if (k == 2) src_q[3].push_back(wd(3, 0, 0, 1'b1));
      end
      chk("sop_rel_cur", s_cur, 2'd3);
      chk("sop_rel_drain", exp_q.size(), 0);

      // Reset during beat 2 of a 4-beat packet; weights and rotation restart.
      do_reset();
      cfg_write(2'd0, 4'd0);
      for (int b = 0; b < 4; b++) src_q[2].push_back(wd(2, 0, b, b == 3));
      src_q[0].push_back(wd(0, 0, 0, 1'b1));
      src_q[0].push_back(wd(0, 1, 0, 1'b1));
      for (int b = 0; b < 3; b++) exp_q.push_back(wd(2, 0, b, 1'b0));
      cycle();
      chk("rst_pre_granted", s_gr, 1'b0);
      cycle();
      chk("rst_pre_cur", s_cur, 2'd2);
      cycle();
      sh_rst = 1'b0;
      cycle();
      sh_rst = 1'b1;
      chk("rst_partial_drain", exp_q.size(), 0);
      src_q[2].delete();
      src_q[2].push_back(wd(2, 1, 0, 1'b1));
      exp_q.push_back(wd(0, 0, 0, 1'b1));
      exp_q.push_back(wd(2, 1, 0, 1'b1));
      exp_q.push_back(wd(0, 1, 0, 1'b1));
      cycle();
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_ready", s_ready, 4'b0000);
      chk("rst_granted", s_gr, 1'b0);
      chk("rst_cur", s_cur, 2'd0);
      cycle();
      chk("rst_first_granted", s_gr, 1'b1);
      chk("rst_first_cur", s_cur, 2'd0);
      drain("rst_after_timeout", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
